// File: rtl/led_matrix_pkg.sv
// rtl/led_matrix_pkg.sv - shared types and constants for the 8x8 RGB LED matrix scanner
package led_matrix_pkg;

    localparam int ROWS = 8;
    localparam int COLS = 8;

    localparam logic [7:0] COL_OFF = 8'hFF;
    localparam logic [7:0] ROW_OFF = 8'h00;

    typedef enum logic {
        SCAN,
        BLANK
    } scan_state_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_row_t;

endpackage

// File: rtl/led_frame_bank.sv
// rtl/led_frame_bank.sv - double-buffered 8x8x3 frame store, sync write port, combinational read port
module led_frame_bank
    import led_matrix_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic       wr_bank,
    input  logic [2:0] wr_row,
    input  rgb_row_t   wr_data,
    input  logic       rd_bank,
    input  logic [2:0] rd_row,
    output rgb_row_t   rd_data
);

    rgb_row_t mem [2][ROWS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < 2; b++) begin
                for (int r = 0; r < ROWS; r++) begin
                    mem[b][r] <= '0;
                end
            end
        end else if (wr_en) begin
            mem[wr_bank][wr_row] <= wr_data;
        end
    end

    assign rd_data = mem[rd_bank][rd_row];

endmodule

// File: rtl/led_matrix_scanner.sv
// rtl/led_matrix_scanner.sv - row-scanning refresh controller with tear-free bank swap
// Optional inter-row blanking is built in when LED_SCAN_BLANKING_EN is defined.
module led_matrix_scanner
    import led_matrix_pkg::*;
#(
    parameter int ROW_CYCLES   = 6250,
    parameter int BLANK_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_valid,
    output logic       wr_ready,
    input  logic [2:0] wr_row,
    input  logic [7:0] wr_r,
    input  logic [7:0] wr_g,
    input  logic [7:0] wr_b,
    input  logic       swap_req,
    output logic       swap_ack,
    output logic       frame_start,
    output logic [7:0] led_row,
    output logic [7:0] led_col_r,
    output logic [7:0] led_col_g,
    output logic [7:0] led_col_b
);

    localparam int CNT_MAX = (ROW_CYCLES > BLANK_CYCLES) ? ROW_CYCLES : BLANK_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    scan_state_t      state, state_nxt;
    logic             started;
    logic [2:0]       row, row_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             front, front_nxt;
    logic             swap_pending, pending_nxt;
    logic             boundary, ack, drive;
    rgb_row_t         rd_data;

    always_comb begin
        state_nxt = state;
        row_nxt   = row;
        cnt_nxt   = cnt + 1'b1;
        boundary  = 1'b0;
        drive     = 1'b1;
        if (!started) begin
            // first edge out of reset opens row 0 like a frame boundary
            state_nxt = SCAN;
            row_nxt   = 3'd0;
            cnt_nxt   = '0;
            boundary  = 1'b1;
        end else begin
            case (state)
                SCAN: begin
                    if (cnt == CNT_W'(ROW_CYCLES - 1)) begin
                        cnt_nxt = '0;
`ifdef LED_SCAN_BLANKING_EN
                        state_nxt = BLANK;
                        drive     = 1'b0;
`else
                        row_nxt  = row + 3'd1;
                        boundary = (row == 3'd7);
`endif
                    end
                end
                default: begin
`ifdef LED_SCAN_BLANKING_EN
                    drive = 1'b0;
                    if (cnt == CNT_W'(BLANK_CYCLES - 1)) begin
                        cnt_nxt   = '0;
                        state_nxt = SCAN;
                        row_nxt   = row + 3'd1;
                        boundary  = (row == 3'd7);
                        drive     = 1'b1;
                    end
`else
                    state_nxt = SCAN;
                    cnt_nxt   = '0;
`endif
                end
            endcase
        end
        ack         = boundary & swap_pending;
        front_nxt   = front ^ ack;
        // a request seen in the boundary cycle survives the clear and waits a frame
        pending_nxt = swap_req | (swap_pending & ~boundary);
    end

    led_frame_bank u_bank (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_valid & wr_ready),
        .wr_bank (~front),
        .wr_row  (wr_row),
        .wr_data ({wr_r, wr_g, wr_b}),
        .rd_bank (front_nxt),
        .rd_row  (row_nxt),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= SCAN;
            started      <= 1'b0;
            row          <= 3'd0;
            cnt          <= '0;
            front        <= 1'b0;
            swap_pending <= 1'b0;
            swap_ack     <= 1'b0;
            frame_start  <= 1'b0;
            led_row      <= ROW_OFF;
            led_col_r    <= COL_OFF;
            led_col_g    <= COL_OFF;
            led_col_b    <= COL_OFF;
        end else begin
            state        <= state_nxt;
            started      <= 1'b1;
            row          <= row_nxt;
            cnt          <= cnt_nxt;
            front        <= front_nxt;
            swap_pending <= pending_nxt;
            swap_ack     <= ack;
            frame_start  <= boundary;
            led_row      <= drive ? (8'b1 << row_nxt) : ROW_OFF;
            led_col_r    <= drive ? ~rd_data.r : COL_OFF;
            led_col_g    <= drive ? ~rd_data.g : COL_OFF;
            led_col_b    <= drive ? ~rd_data.b : COL_OFF;
        end
    end

    assign wr_ready = ~swap_pending;

endmodule

// File: tb/tb_led_matrix_scanner.sv
// tb/tb_led_matrix_scanner.sv - scoreboard bench for led_matrix_scanner against a cycle-index reference model
module tb_led_matrix_scanner;

    localparam int RC = 4;
    localparam int BC = 2;
`ifdef LED_SCAN_BLANKING_EN
    localparam int P = RC + BC;
`else
    localparam int P = RC;
`endif
    localparam int F = 8 * P;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_valid = 1'b0;
    logic       wr_ready;
    logic [2:0] wr_row = 3'd0;
    logic [7:0] wr_r = 8'h00, wr_g = 8'h00, wr_b = 8'h00;
    logic       swap_req = 1'b0;
    logic       swap_ack, frame_start;
    logic [7:0] led_row, led_col_r, led_col_g, led_col_b;

    led_matrix_scanner #(.ROW_CYCLES(RC), .BLANK_CYCLES(BC)) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_row      (wr_row),
        .wr_r        (wr_r),
        .wr_g        (wr_g),
        .wr_b        (wr_b),
        .swap_req    (swap_req),
        .swap_ack    (swap_ack),
        .frame_start (frame_start),
        .led_row     (led_row),
        .led_col_r   (led_col_r),
        .led_col_g   (led_col_g),
        .led_col_b   (led_col_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         k;
        logic [7:0] row, r, g, b;
        logic       fs, ack, rdy;
    } exp_t;

    exp_t       q[$];
    int         checks = 0;
    int         failures = 0;
    bit         mon_en = 1'b0;

    logic [23:0] mbank [2][8];
    int          mfront;
    bit          mpend;
    int          k;

    task automatic chk(input string name, input int kk, input logic [7:0] got, input logic [7:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%h expected=%h", name, kk, got, want);
        end
    endtask

    function automatic void push_exp(input bit ack);
        exp_t e;
        int pos, ri;
        pos = k % P;
        ri  = (k / P) % 8;
        e.k   = k;
        e.row = (pos < RC) ? (8'd1 << ri) : 8'h00;
        e.r   = (pos < RC) ? ~mbank[mfront][ri][23:16] : 8'hFF;
        e.g   = (pos < RC) ? ~mbank[mfront][ri][15:8]  : 8'hFF;
        e.b   = (pos < RC) ? ~mbank[mfront][ri][7:0]   : 8'hFF;
        e.fs  = (k % F) == 0;
        e.ack = ack;
        e.rdy = !mpend;
        q.push_back(e);
    endfunction

    function automatic void model_reset();
        for (int b = 0; b < 2; b++)
            for (int r = 0; r < 8; r++)
                mbank[b][r] = 24'h0;
        mfront = 0;
        mpend  = 1'b0;
        k      = 0;
    endfunction

    // Drives one cycle of stimulus and predicts the following cycle.
    task automatic step(input bit v, input logic [2:0] wrow, input logic [7:0] r, input logic [7:0] g,
                        input logic [7:0] b, input bit req);
        bit bnd, ack;
        wr_valid = v;
        wr_row   = wrow;
        wr_r     = r;
        wr_g     = g;
        wr_b     = b;
        swap_req = req;
        if (v && !mpend) mbank[1 - mfront][wrow] = {r, g, b};
        k++;
        bnd = (k % F) == 0;
        ack = bnd && mpend;
        if (ack) mfront = 1 - mfront;
        mpend = req || (mpend && !bnd);
        push_exp(ack);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 3'd0, 8'h00, 8'h00, 8'h00, 1'b0);
    endtask

    task automatic check_reset_outputs();
        chk("rst_led_row", -1, led_row, 8'h00);
        chk("rst_col_r", -1, led_col_r, 8'hFF);
        chk("rst_col_g", -1, led_col_g, 8'hFF);
        chk("rst_col_b", -1, led_col_b, 8'hFF);
        chk("rst_frame_start", -1, {7'd0, frame_start}, 8'h00);
        chk("rst_swap_ack", -1, {7'd0, swap_ack}, 8'h00);
        chk("rst_wr_ready", -1, {7'd0, wr_ready}, 8'h01);
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        push_exp(1'b0);
        @(posedge clk);
        #1;
        mon_en = 1'b1;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL scoreboard_underflow got=empty expected=entry");
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("led_row", e.k, led_row, e.row);
                chk("led_col_r", e.k, led_col_r, e.r);
                chk("led_col_g", e.k, led_col_g, e.g);
                chk("led_col_b", e.k, led_col_b, e.b);
                chk("frame_start", e.k, {7'd0, frame_start}, {7'd0, e.fs});
                chk("swap_ack", e.k, {7'd0, swap_ack}, {7'd0, e.ack});
                chk("wr_ready", e.k, {7'd0, wr_ready}, {7'd0, e.rdy});
            end
        end
    end

    initial begin
        model_reset();
        #12;
        check_reset_outputs();
        release_reset();

        // plain walk through two frames
        idle(2 * F);

        // row 3 red corners, then swap
        step(1'b1, 3'd3, 8'h81, 8'h00, 8'h00, 1'b0);
        step(1'b0, 3'd0, 8'h00, 8'h00, 8'h00, 1'b1);
        idle(F + 4 * P);

        // write held high while a swap is pending
        step(1'b1, 3'd5, 8'h11, 8'h22, 8'h33, 1'b1);
        for (int i = 0; i < F + P; i++) step(1'b1, 3'((i % 8)), 8'($urandom), 8'($urandom), 8'($urandom), 1'b0);
        idle(2);

        // three requests inside one frame, then a request landing on the boundary cycle
        step(1'b0, 3'd0, 8'h00, 8'h00, 8'h00, 1'b1);
        idle(3);
        step(1'b0, 3'd0, 8'h00, 8'h00, 8'h00, 1'b1);
        idle(5);
        step(1'b0, 3'd0, 8'h00, 8'h00, 8'h00, 1'b1);
        while (((k + 1) % F) != 0) idle(1);
        step(1'b0, 3'd0, 8'h00, 8'h00, 8'h00, 1'b1);
        idle(2 * F);

        // randomized traffic
        for (int i = 0; i < 20 * F; i++) begin
            step(($urandom % 3) == 0, 3'($urandom % 8), 8'($urandom), 8'($urandom), 8'($urandom),
                 ($urandom % 24) == 0);
        end

        // reset mid-row 5 with a swap pending
        while (((k / P) % 8) != 4) step(1'b1, 3'($urandom % 8), 8'($urandom), 8'hA5, 8'h5A, 1'b0);
        step(1'b0, 3'd0, 8'h00, 8'h00, 8'h00, 1'b1);
        while (!(((k / P) % 8) == 5 && (k % P) == 1)) idle(1);
        mon_en = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs();
        q.delete();
        wr_valid = 1'b0;
        swap_req = 1'b0;
        @(posedge clk);
        release_reset();
        idle(2 * F);

        @(negedge clk);
        #1;
        mon_en = 1'b0;
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got=%0d expected=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1);
    end

endmodule
